rr_grant_scheduler: RTL and testbench
=====================================

# rr_grant_scheduler

Round-robin scheduler that shares a single downstream resource among 16 requesters. Each cycle it picks the next requester using a rotating-priority search built from the team's 16-bit priority-encoding datapath. It holds the grant until the requester releases, drops its request, or exceeds a hold budget. It sits between the requester bank and the shared resource and drives that resource's select index.

## Interface
Parameters:
- NREQ, 16, number of requesters (fixed at 16 for this revision)
- IDXW, 4, width of grant index, equal to log2(NREQ)
- HOLD_MAX, 255, maximum cycles a grant is held; 0 disables the timeout
- HOLD_W, 8, hold counter width; must satisfy HOLD_MAX < 2^HOLD_W

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  16  request vector, one bit per requester
- release  in  1  current owner finished; 1-cycle pulse, sampled only in GRANT
- gnt_valid  out  1  a grant is active
- gnt_idx  out  4  index of current owner; 0 when gnt_valid=0
- gnt_onehot  out  16  one-hot of gnt_idx; 0 when gnt_valid=0
- timeout  out  1  1-cycle pulse: previous grant was revoked by hold budget
- ptr  out  4  current round-robin start pointer (debug/observability)

## Operation
- States: IDLE, GRANT.
- Reset: state=IDLE, ptr=0, hold counter=0. All outputs are 0.
- IDLE:
  - If |req=1, pick the first set bit of req scanning upward from ptr, wrapping 15→0.
  - Register the pick into gnt_idx and gnt_onehot, set gnt_valid=1, clear the hold counter, and go to GRANT.
  - If req=0, stay in IDLE.
- GRANT: the hold counter increments each cycle. Exit conditions, evaluated on inputs in the current cycle:
  - release=1, or
  - req[gnt_idx]=0, or
  - HOLD_MAX≠0 and counter==HOLD_MAX-1.
- On exit:
  - state=IDLE, gnt_valid=0.
  - ptr = (gnt_idx+1) mod 16, with natural 4-bit wrap.
  - timeout=1 in the following cycle only if the budget was the sole exit cause.
- Priority of simultaneous exit causes: release or req-drop beats timeout. A coincident budget expiry produces no timeout pulse.
- release in IDLE is ignored. Requests from other requesters during GRANT never pre-empt.
- Exactly one IDLE cycle separates consecutive grants. This is the deterministic bubble.
- No requester is starved: each asserted requester is granted within 15 grants.

## Timing
- Request to grant: req sampled in IDLE at cycle t gives gnt_valid=1 at t+1.
- Release to drop: exit condition at cycle t gives gnt_valid=0 at t+1. Earliest next grant is at t+2.
- With the timeout active, gnt_valid is high for at most HOLD_MAX consecutive cycles.
- ptr updates on the same edge that gnt_valid falls.
- rst asserted mid-grant: all outputs are 0 on the next edge, ptr=0, and any pending timeout pulse is suppressed.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package rr_sched_pkg holds:
  - NREQ and IDXW constants
  - state enum {IDLE, GRANT}
  - function for the one-hot/index conversion
- Sub-module rr_prio_pick (combinational) takes req[15:0] and ptr[3:0] and produces found and idx[3:0].
  - Pass 1: priority encode req masked to bits ≥ptr, taking the lowest set index.
  - Pass 2: if pass 1 is empty, encode unmasked req.
- rr_grant_scheduler holds the FSM, hold counter, ptr register and output registers.

## Test plan
- Reset then req=16'h0001 at cycle 0 → gnt_valid=1, gnt_idx=0 and gnt_onehot=16'h0001 at cycle 1; release at cycle 3 → gnt_valid=0 at cycle 4, ptr=1.
- req=16'h8001 held, release pulsed each grant → gnt_idx sequence is 0, 15, 0, 15, with one idle cycle between grants and ptr alternating 1, 0.
- HOLD_MAX=4, req=16'h0004 held, no release → gnt_valid high for exactly 4 cycles, timeout=1 in the next cycle, ptr=3, then re-grant of idx 2 via wrap after the idle cycle.
- HOLD_MAX=4, release asserted in the 4th grant cycle → gnt_valid drops and timeout stays 0.
- req=16'hFFFF, ptr=14, owner idx 14 drops req[14] → gnt_valid=0 next cycle, ptr=15, next grant idx 15, then idx 0.
- rst asserted during GRANT with gnt_idx=7 → next cycle all outputs are 0 and ptr=0; with req=16'h0080 held, re-grant of idx 7 one cycle after rst deasserts.

Source files
------------

// File: rtl/rr_sched_pkg.sv
// Shared constants, state encoding and index helpers for the round-robin
// grant scheduler and its priority picker.
package rr_sched_pkg;

   localparam int NREQ = 16;
   localparam int IDXW = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Index to one-hot conversion used for the registered grant vector.
   function automatic logic [NREQ-1:0] idx2onehot(input logic [IDXW-1:0] idx);
      return NREQ'(1) << idx;
   endfunction

   // Lowest set bit of a request vector; returns 0 when the vector is empty.
   function automatic logic [IDXW-1:0] lowest_idx(input logic [NREQ-1:0] vec);
      logic [IDXW-1:0] res;
      res = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (vec[i]) res = IDXW'(i);
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating-priority pick: first set request at or above ptr,
// falling back to the lowest set request overall (the 15 -> 0 wrap).
module rr_prio_pick
   import rr_sched_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic            found,
   output logic [IDXW-1:0] idx
);

   logic [NREQ-1:0] upper_mask;
   logic [NREQ-1:0] req_upper;
   logic [IDXW-1:0] idx_upper;
   logic [IDXW-1:0] idx_any;

   // Thermometer mask selecting requesters at or above the start pointer.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
         assign upper_mask[gi] = (IDXW'(gi) >= ptr);
      end
   endgenerate

   assign req_upper = req & upper_mask;

   // Two priority-encode passes: the masked one wins if it finds anything.
   always_comb begin
      idx_upper = lowest_idx(req_upper);
      idx_any   = lowest_idx(req);
      found     = |req;
      idx       = (|req_upper) ? idx_upper : idx_any;
   end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler sharing one downstream resource among 16 requesters.
// A grant is held until the owner releases, drops its request, or exhausts
// the hold budget; one idle cycle always separates consecutive grants.
module rr_grant_scheduler #(
   parameter int NREQ     = 16,
   parameter int IDXW     = 4,
   parameter int HOLD_MAX = 255,
   parameter int HOLD_W   = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            release_i,   // "release" is a reserved word
   output logic            gnt_valid,
   output logic [IDXW-1:0] gnt_idx,
   output logic [NREQ-1:0] gnt_onehot,
   output logic            timeout,
   output logic [IDXW-1:0] ptr
);
   import rr_sched_pkg::*;

   // Counter value seen in the last permitted grant cycle.
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

   state_t            state_q;
   logic              gnt_valid_q;
   logic [IDXW-1:0]   gnt_idx_q;
   logic [NREQ-1:0]   gnt_onehot_q;
   logic              timeout_q;
   logic [IDXW-1:0]   ptr_q;
   logic [HOLD_W-1:0] hold_q;
   logic [HOLD_W-1:0] hold_d;

   logic              pick_found;
   logic [IDXW-1:0]   pick_idx;
   logic              exit_user;
   logic              exit_budget;

   rr_prio_pick u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Owner-driven exits take precedence over the hold budget.
   assign exit_user   = release_i | ~req[gnt_idx_q];
   assign exit_budget = (HOLD_MAX != 0) && (hold_q == HOLD_LAST);
   assign hold_d      = HOLD_W'(hold_q + 1'b1);

   // Grant FSM with registered outputs, pointer and hold counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         gnt_valid_q  <= 1'b0;
         gnt_idx_q    <= '0;
         gnt_onehot_q <= '0;
         timeout_q    <= 1'b0;
         ptr_q        <= '0;
         hold_q       <= '0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  state_q      <= GRANT;
                  gnt_valid_q  <= 1'b1;
                  gnt_idx_q    <= pick_idx;
                  gnt_onehot_q <= idx2onehot(pick_idx);
                  hold_q       <= '0;
               end
            end
            GRANT: begin
               if (exit_user || exit_budget) begin
                  state_q      <= IDLE;
                  gnt_valid_q  <= 1'b0;
                  gnt_idx_q    <= '0;
                  gnt_onehot_q <= '0;
                  ptr_q        <= IDXW'(gnt_idx_q + 1'b1);
                  timeout_q    <= exit_budget && !exit_user;
               end else begin
                  hold_q <= hold_d;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt_valid  = gnt_valid_q;
   assign gnt_idx    = gnt_idx_q;
   assign gnt_onehot = gnt_onehot_q;
   assign timeout    = timeout_q;
   assign ptr        = ptr_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed plus randomized bench for rr_grant_scheduler with a short hold
// budget, checked every cycle against a behavioural round-robin model.
module tb_rr_grant_scheduler;

   localparam int HM = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] req;
   logic        rel;
   logic        gnt_valid;
   logic [3:0]  gnt_idx;
   logic [15:0] gnt_onehot;
   logic        timeout;
   logic [3:0]  ptr;

   int tests = 0;
   int fails = 0;

   // Model state: owner index (-1 when nobody holds the resource), round-robin
   // start position, cycles already spent by the owner, pending timeout flag.
   int m_owner = -1;
   int m_start = 0;
   int m_held  = 0;
   bit m_to    = 1'b0;

   rr_grant_scheduler #(
      .NREQ     (16),
      .IDXW     (4),
      .HOLD_MAX (HM),
      .HOLD_W   (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .release_i  (rel),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx),
      .gnt_onehot (gnt_onehot),
      .timeout    (timeout),
      .ptr        (ptr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance the model by one clock using the inputs presented this cycle.
   task automatic model_step();
      bit user_exit;
      bit budget_exit;
      bit found;
      if (rst) begin
         m_owner = -1;
         m_start = 0;
         m_held  = 0;
         m_to    = 1'b0;
         return;
      end
      m_to = 1'b0;
      if (m_owner < 0) begin
         found = 1'b0;
         for (int k = 0; k < 16; k++) begin
            int cand;
            cand = (m_start + k) % 16;
            if (!found && req[cand]) begin
               found   = 1'b1;
               m_owner = cand;
               m_held  = 0;
            end
         end
      end else begin
         user_exit   = rel || !req[m_owner];
         budget_exit = (HM != 0) && (m_held + 1 == HM);
         if (user_exit || budget_exit) begin
            m_start = (m_owner + 1) % 16;
            m_to    = budget_exit && !user_exit;
            m_owner = -1;
         end else begin
            m_held++;
         end
      end
   endtask

   // One clock: update the model at the edge, compare all outputs just after.
   task automatic cycle();
      logic [31:0] exp_oh;
      @(posedge clk);
      model_step();
      #1;
      exp_oh = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      chk("gnt_valid", gnt_valid, (m_owner >= 0) ? 32'd1 : 32'd0);
      chk("gnt_idx", gnt_idx, (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk("gnt_onehot", gnt_onehot, exp_oh);
      chk("timeout", timeout, 32'(m_to));
      chk("ptr", ptr, 32'(m_start));
      $display("[TB] t=%0t rst=%0b req=%04h rel=%0b -> valid=%0b idx=%0d oh=%04h to=%0b ptr=%0d",
               $time, rst, req, rel, gnt_valid, gnt_idx, gnt_onehot, timeout, ptr);
   endtask

   initial begin
      rst = 1'b1;
      req = 16'h0000;
      rel = 1'b0;
      cycle();
      cycle();
      chk("reset_valid", gnt_valid, 0);
      chk("reset_onehot", gnt_onehot, 0);
      chk("reset_ptr", ptr, 0);

      // Single requester, release after a few cycles.
      rst = 1'b0;
      req = 16'h0001;
      cycle();
      chk("t1_valid", gnt_valid, 1);
      chk("t1_idx", gnt_idx, 0);
      chk("t1_onehot", gnt_onehot, 16'h0001);
      cycle();
      cycle();
      rel = 1'b1;
      cycle();
      rel = 1'b0;
      req = 16'h0000;
      chk("t1_drop", gnt_valid, 0);
      chk("t1_ptr", ptr, 1);

      // Two requesters alternate around the wrap.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      req = 16'h8001;
      for (int g = 0; g < 4; g++) begin
         cycle();
         chk("t2_idx", gnt_idx, (g % 2 == 0) ? 0 : 15);
         rel = 1'b1;
         cycle();
         rel = 1'b0;
         chk("t2_bubble", gnt_valid, 0);
         chk("t2_ptr", ptr, (g % 2 == 0) ? 1 : 0);
      end

      // Hold budget expiry and wrap re-grant.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      req = 16'h0004;
      cycle();
      chk("t3_idx", gnt_idx, 2);
      for (int c = 0; c < HM - 1; c++) begin
         cycle();
         chk("t3_hold", gnt_valid, 1);
      end
      cycle();
      chk("t3_drop", gnt_valid, 0);
      chk("t3_timeout", timeout, 1);
      chk("t3_ptr", ptr, 3);
      cycle();
      chk("t3_regrant", gnt_idx, 2);
      chk("t3_to_clear", timeout, 0);

      // Release coinciding with budget expiry gives no timeout.
      for (int c = 0; c < HM - 1; c++) cycle();
      rel = 1'b1;
      cycle();
      rel = 1'b0;
      req = 16'h0000;
      chk("t4_drop", gnt_valid, 0);
      chk("t4_no_timeout", timeout, 0);

      // Request drop by owner 14 with all requesting.
      req = 16'h2000;
      cycle();
      rel = 1'b1;
      cycle();
      rel = 1'b0;
      chk("t5_ptr14", ptr, 14);
      req = 16'hFFFF;
      cycle();
      chk("t5_idx14", gnt_idx, 14);
      req = 16'hBFFF;
      cycle();
      chk("t5_drop", gnt_valid, 0);
      chk("t5_ptr15", ptr, 15);
      cycle();
      chk("t5_idx15", gnt_idx, 15);
      rel = 1'b1;
      cycle();
      rel = 1'b0;
      cycle();
      chk("t5_idx0", gnt_idx, 0);
      chk("t5_valid0", gnt_valid, 1);

      // Reset during a grant, right on budget expiry.
      rel = 1'b1;
      cycle();
      rel = 1'b0;
      req = 16'h0080;
      cycle();
      chk("t6_idx7", gnt_idx, 7);
      for (int c = 0; c < HM - 1; c++) cycle();
      rst = 1'b1;
      cycle();
      chk("t6_valid", gnt_valid, 0);
      chk("t6_idx", gnt_idx, 0);
      chk("t6_timeout", timeout, 0);
      chk("t6_ptr", ptr, 0);
      rst = 1'b0;
      cycle();
      chk("t6_regrant", gnt_idx, 7);
      cycle();
      chk("t6_no_timeout", timeout, 0);

      // Randomized traffic against the model.
      req = 16'($urandom);
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 15)] = ~req[$urandom_range(0, 15)];
         if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 15)] = 1'b1;
         if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 15)] = 1'b0;
         rel = ($urandom_range(0, 4) == 0);
         rst = ($urandom_range(0, 99) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
